// File: rtl/four_bit_register.sv
// four_bit_register
//   WIDTH-bit holding register with a synchronous set and a clock enable.
//   At each rising clk edge, in priority order:
//     set = 1          -> load SET_VALUE (default all ones)
//     ce  = 1          -> load din
//     otherwise        -> hold
//   dout comes straight from the register. No input reaches it combinationally.
//
// Ports
//   clk   in   1      rising-edge clock
//   set   in   1      synchronous active-high set, loads SET_VALUE
//   ce    in   1      clock enable, active-high
//   din   in   WIDTH  data to capture
//   dout  out  WIDTH  registered contents
module four_bit_register #(
  parameter int unsigned          WIDTH     = 4,
  parameter logic [WIDTH-1:0]     SET_VALUE = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             set,
  input  logic             ce,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] data_q, data_d;

  // Next state. set beats ce. X/Z on din passes through unchanged.
  always_comb begin
    data_d = data_q;
    if (set)     data_d = SET_VALUE;
    else if (ce) data_d = din;
  end

  // There is no separate reset branch here. set is this block's reset, and
  // it is already covered by the next-state logic above.
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign dout = data_q;

endmodule

// File: tb/tb_four_bit_register.sv
module tb_four_bit_register;
  localparam int W = 4;
  localparam logic [W-1:0] ONES = 4'b1111;

  logic         clk = 1'b0;
  logic         set = 1'b0;
  logic         ce  = 1'b0;
  logic [W-1:0] din = '0;
  logic [W-1:0] dout;

  int vectors     = 0;
  int miscompares = 0;

  logic [W-1:0] model_q = 'x;
  logic [W-1:0] exp_q[$];

  four_bit_register #(.WIDTH(W)) dut (
    .clk (clk),
    .set (set),
    .ce  (ce),
    .din (din),
    .dout(dout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs just after an edge and push the expected result.
  // Then wait for the next edge and compare dout against the popped value.
  task automatic step(input string tag, input logic s, input logic e, input logic [W-1:0] d);
    set = s; ce = e; din = d;
    if (s)      model_q = ONES;
    else if (e) model_q = d;
    exp_q.push_back(model_q);
    @(posedge clk); #1;
    if (exp_q.size() == 0) begin
      vectors++; miscompares++;
      $error("FAIL %s: observed empty-queue expected entry", tag);
    end else begin
      check(tag, dout, exp_q.pop_front());
    end
  endtask

  initial begin
    @(posedge clk); #1;

    // 1: set loads all ones, regardless of ce=0 and din=0
    step("set_reset", 1'b1, 1'b0, 4'b0000);
    check("reset_value", dout, ONES);

    // 2: enabled loads
    step("load_0001", 1'b0, 1'b1, 4'b0001);
    step("load_0010", 1'b0, 1'b1, 4'b0010);

    // 3: hold for three edges while ce=0, then load
    step("load_0001b", 1'b0, 1'b1, 4'b0001);
    for (int i = 0; i < 3; i++) step("hold_ce0", 1'b0, 1'b0, 4'b0110);
    check("hold_const", dout, 4'b0001);
    step("load_0110", 1'b0, 1'b1, 4'b0110);

    // 4: set wins over ce, then the first edge after set drops loads din
    step("set_prio", 1'b1, 1'b1, 4'b0000);
    check("set_prio_const", dout, ONES);
    step("set_release", 1'b0, 1'b1, 4'b0010);

    // 5: a set pulse between edges is ignored
    step("load_0101", 1'b0, 1'b1, 4'b0101);
    ce = 1'b0;
    #1 set = 1'b1;
    #2 set = 1'b0;
    #1 check("mid_pulse", dout, 4'b0101);
    step("after_pulse", 1'b0, 1'b0, 4'b0000);
    check("after_pulse_const", dout, 4'b0101);

    // 6: din changes mid-cycle do not reach dout before the edge
    set = 1'b0; ce = 1'b1; din = 4'b1010;
    #2 check("no_feedthru", dout, 4'b0101);
    din = 4'b0011;
    #1 check("no_feedthru2", dout, 4'b0101);
    step("edge_load_0011", 1'b0, 1'b1, 4'b0011);

    // ce toggling between edges has no effect; only the edge value counts
    ce = 1'b1; #1 ce = 1'b0; #1;
    step("ce_glitch", 1'b0, 1'b0, 4'b1100);
    check("ce_glitch_const", dout, 4'b0011);

    // X on din propagates when loaded
    step("x_prop", 1'b0, 1'b1, 4'bx0x1);
    step("x_cleared_by_set", 1'b1, 1'b0, 4'bxxxx);
    step("all_zero", 1'b0, 1'b1, 4'b0000);

    // a short burst of random traffic against the model
    for (int i = 0; i < 20; i++)
      step("random", ($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1,
           4'($urandom_range(0, 15)));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no-finish expected finish");
    $fatal(1);
  end
endmodule
